// File: rtl/sat_accum.sv
// -----------------------------------------------------------------------------
// sat_accum -- job-based saturating signed 16-bit accumulator.
//
// A job starts with a single-cycle start pulse carrying a beat count (len).
// The block then accepts exactly len beats over a valid/ready handshake.
// Each beat adds or subtracts a signed 16-bit operand, and the running value
// is clamped to the signed 16-bit range. After the last beat the result is
// presented with out_valid until the consumer takes it. abort cancels the
// job from any state.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a job (sampled only in IDLE)
//   len        in   beat count, sampled with start (0 = empty job)
//   abort      in   synchronous cancel, highest priority
//   in_valid   in   in_data/in_sub valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   in_data    in   signed two's-complement operand
//   in_sub     in   1 = subtract in_data, 0 = add in_data
//   out_valid  out  result and flags valid
//   out_ready  in   consumer takes the result
//   result     out  saturated accumulator value
//   flag_n     out  result is negative
//   flag_z     out  result is zero
//   flag_v     out  some beat of this job saturated (sticky)
//   busy       out  a job is in progress (state is not IDLE)
// -----------------------------------------------------------------------------
module sat_accum #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             flag_v_q, flag_v_d;

    logic [16:0]      exact;
    logic [15:0]      sat_val;
    logic             sat_hit;
    logic             xfer;

    // Exact 17-bit result of the beat. Sign-extending both operands keeps
    // subtracting 0x8000 correct: the subtrahend is -32768, so the result
    // gains +32768 and lands in the positive-overflow region when needed.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a value
        // on every path (defaults first); otherwise a latch is inferred.
        exact   = '0;
        sat_val = '0;
        sat_hit = 1'b0;
        if (in_sub) begin
            exact = {acc_q[15], acc_q} - {in_data[15], in_data};
        end else begin
            exact = {acc_q[15], acc_q} + {in_data[15], in_data};
        end
        // Bits 16 and 15 disagree exactly when the value is outside the
        // 16-bit signed range; bit 16 gives the direction.
        if (exact[16] != exact[15]) begin
            sat_hit = 1'b1;
            sat_val = exact[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat_val = exact[15:0];
        end
    end

    assign xfer = in_valid && (state_q == ST_ACCUM);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        flag_v_d = flag_v_q;

        if (abort) begin
            state_d  = ST_IDLE;
            acc_d    = '0;
            rem_d    = '0;
            flag_v_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_d    = '0;
                        flag_v_d = 1'b0;
                        rem_d    = len;
                        state_d  = (len == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (xfer) begin
                        acc_d    = sat_val;
                        flag_v_d = flag_v_q | sat_hit;
                        rem_d    = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            flag_v_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the pre-edge values of the others.
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            flag_v_q <= flag_v_d;
        end
    end

    // All outputs come from registers or the state decode only.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = acc_q;
    assign flag_n    = acc_q[15];
    assign flag_z    = (acc_q == 16'h0000);
    assign flag_v    = flag_v_q;

endmodule
